aq_axis_arb64: RTL and testbench
================================

// Module: aq_axis_arb64
// PURPOSE
// - Packet-granular round-robin arbiter sharing one 64-bit AXI-Stream among NCH requesters.
// - Sits directly upstream of the 64->32 downconverter: its O_AXIS_* drives that converter's 64-bit input.
// - A grant is held from first beat to TLAST so packets never interleave.
// - Watchdog releases a grant whose requester stalls mid-packet.
// PARAMETERS
// NCH      4     number of requesters (2..8)
// TMO      255   idle cycles with grant held and source TVALID low before forced release (1..65535)
// PORTS
// I_AXIS_TCLK    in   1         single clock for all ports
// ARESETN        in   1         reset, synchronous, active-low
// I_AXIS_TDATA   in   NCH*64    requester data, channel n at [n*64+63:n*64]
// I_AXIS_TSTRB   in   NCH*8     requester byte strobes, channel n at [n*8+7:n*8]
// I_AXIS_TLAST   in   NCH       per-channel end of packet
// I_AXIS_TVALID  in   NCH       per-channel valid
// I_AXIS_TREADY  out  NCH       per-channel ready
// O_AXIS_TDATA   out  64        to downconverter
// O_AXIS_TSTRB   out  8         to downconverter
// O_AXIS_TLAST   out  1         to downconverter
// O_AXIS_TVALID  out  1         to downconverter
// O_AXIS_TREADY  in   1         from downconverter
// O_GRANT        out  3         index of channel currently granted (valid when O_BUSY=1)
// O_BUSY         out  1         grant held (state LOCK)
// O_TMO          out  1         one-cycle pulse on watchdog release
// BEHAVIOUR
// - Reset (ARESETN=0 at clock edge): state=IDLE, last=NCH-1, tmo_cnt=0, O_GRANT=0, O_BUSY=0, O_TMO=0.
//   Outputs O_AXIS_TVALID=0, I_AXIS_TREADY=0 while in IDLE. Reset mid-packet aborts; the packet tail is not flushed.
// - IDLE: if any I_AXIS_TVALID, pick first valid channel scanning last+1, last+2, ... (mod NCH).
//   Register it into O_GRANT, go LOCK. One-cycle arbitration bubble; no data passes in IDLE.
// - LOCK with g=O_GRANT: combinational pass-through, zero added latency.
//   O_AXIS_TDATA/TSTRB/TLAST/TVALID = channel g.
//   I_AXIS_TREADY[g] = O_AXIS_TREADY; all other ready bits = 0.
// - Beat = O_AXIS_TVALID & O_AXIS_TREADY. A beat with TLAST=1 sets last=g and returns to IDLE next cycle.
//   Single-beat packets are legal.
// - Watchdog:
//   tmo_cnt increments each LOCK cycle with I_AXIS_TVALID[g]=0.
//   tmo_cnt clears on any cycle with I_AXIS_TVALID[g]=1 and on entry to LOCK.
//   When tmo_cnt reaches TMO: go IDLE, last=g, O_TMO=1 for one cycle.
//   Downstream backpressure (valid=1, ready=0) never counts.
// - Simultaneous TLAST beat and watchdog expiry cannot occur (valid=1 clears the count); TLAST path wins by construction.
// - AXIS rules honoured: ready never gates valid; output valid/data stable while O_AXIS_TREADY=0 (inherited from source).
// - Fairness: after a packet from channel k, every other requesting channel is served before k again.
// - tmo_cnt width = clog2(TMO+1); saturates, no wrap.
// STRUCTURE
// - Shared package aq_axis_pkg: AXIS_DW=64, AXIS_SW=8, state enum {IDLE, LOCK}.
// - Sub-module aq_rr_pick: combinational round-robin picker (req[NCH], last -> gnt_idx, any).
// - Top holds FSM, grant/last registers, watchdog counter and output muxes.
// TESTING
// - All 4 channels send 3-beat packets continuously, O_AXIS_TREADY=1.
//   -> grant order 0,1,2,3,0...; each packet contiguous; 1 idle cycle between packets.
// - Ch2 requests alone with 1-beat packets (TDATA=64'hDEADBEEF_00000002).
//   -> O_GRANT=2 every packet, output data matches, 2 cycles per packet.
// - Ch1 mid-packet, O_AXIS_TREADY held 0 for 20 cycles.
//   -> no O_TMO; I_AXIS_TREADY[1]=0; data stable; resumes on ready.
// - TMO=8: ch0 sends 1 beat without TLAST, then TVALID=0.
//   -> O_TMO pulse 8 cycles after stall starts; next grant goes to ch1 if requesting.
// - ARESETN=0 for one cycle during ch3 beat 2 of 4.
//   -> next cycle O_BUSY=0, O_AXIS_TVALID=0; next arbitration starts scan at ch0.
// - Ch0 and ch3 assert TVALID on the same cycle after reset.
//   -> ch0 granted first, ch3 second.

Source files
------------

// File: rtl/aq_axis_pkg.sv
// Shared AXI-Stream widths and arbiter state encoding for the aq_axis blocks.
package aq_axis_pkg;
  localparam int AXIS_DW = 64;
  localparam int AXIS_SW = 8;
  localparam int GW      = 3;   // grant index width, covers up to 8 requesters

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/aq_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping mod NCH.
module aq_rr_pick
  import aq_axis_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req_i,
  input  logic [GW-1:0]  last_i,
  output logic [GW-1:0]  gnt_idx_o,
  output logic           any_o
);

  logic [7:0]    req_pad;
  logic [GW-1:0] cand [NCH];
  logic [NCH-1:0] hit;

  assign req_pad = 8'(req_i);

  // Candidate gi is channel (last + gi + 1) mod NCH, so gi=0 has top priority.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
      logic [GW:0] sum;
      assign sum       = {1'b0, last_i} + (GW+1)'(gi + 1);
      assign cand[gi]  = (sum >= (GW+1)'(NCH)) ? GW'(sum - (GW+1)'(NCH)) : sum[GW-1:0];
      assign hit[gi]   = req_pad[cand[gi]];
    end
  endgenerate

  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        gnt_idx_o = cand[k];
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aq_axis_arb64.sv
// Packet-granular round-robin arbiter merging NCH 64-bit AXI-Stream sources,
// with a watchdog that frees a grant whose source stalls mid-packet.
module aq_axis_arb64
  import aq_axis_pkg::*;
#(
  parameter int NCH = 4,
  parameter int TMO = 255
) (
  input  logic                   I_AXIS_TCLK,
  input  logic                   ARESETN,
  input  logic [NCH*AXIS_DW-1:0] I_AXIS_TDATA,
  input  logic [NCH*AXIS_SW-1:0] I_AXIS_TSTRB,
  input  logic [NCH-1:0]         I_AXIS_TLAST,
  input  logic [NCH-1:0]         I_AXIS_TVALID,
  output logic [NCH-1:0]         I_AXIS_TREADY,
  output logic [AXIS_DW-1:0]     O_AXIS_TDATA,
  output logic [AXIS_SW-1:0]     O_AXIS_TSTRB,
  output logic                   O_AXIS_TLAST,
  output logic                   O_AXIS_TVALID,
  input  logic                   O_AXIS_TREADY,
  output logic [GW-1:0]          O_GRANT,
  output logic                   O_BUSY,
  output logic                   O_TMO
);

  localparam int CW = $clog2(TMO + 1);

  arb_state_e    state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [CW-1:0] tmo_cnt_q;
  logic [CW-1:0] tmo_cnt_d;
  logic          tmo_q;

  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          lock;
  logic          sel_valid;
  logic          beat;
  logic          tmo_hit;

  logic [AXIS_DW-1:0] ch_data [8];
  logic [AXIS_SW-1:0] ch_strb [8];
  logic [7:0]         ch_last;
  logic [7:0]         ch_valid;

  assign lock = (state_q == LOCK);

  // Channels are padded to 8 so the 3-bit grant indexes every mux safely.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < NCH) begin : g_used
        assign ch_data[gi]       = I_AXIS_TDATA[gi*AXIS_DW +: AXIS_DW];
        assign ch_strb[gi]       = I_AXIS_TSTRB[gi*AXIS_SW +: AXIS_SW];
        assign ch_last[gi]       = I_AXIS_TLAST[gi];
        assign ch_valid[gi]      = I_AXIS_TVALID[gi];
        assign I_AXIS_TREADY[gi] = lock && (grant_q == GW'(gi)) && O_AXIS_TREADY;
      end else begin : g_pad
        assign ch_data[gi]  = '0;
        assign ch_strb[gi]  = '0;
        assign ch_last[gi]  = 1'b0;
        assign ch_valid[gi] = 1'b0;
      end
    end
  endgenerate

  aq_rr_pick #(.NCH(NCH)) u_pick (
    .req_i     (I_AXIS_TVALID),
    .last_i    (last_q),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign sel_valid     = ch_valid[grant_q];
  assign O_AXIS_TDATA  = ch_data[grant_q];
  assign O_AXIS_TSTRB  = ch_strb[grant_q];
  assign O_AXIS_TLAST  = ch_last[grant_q];
  assign O_AXIS_TVALID = lock && sel_valid;
  assign beat          = O_AXIS_TVALID && O_AXIS_TREADY;

  assign tmo_cnt_d = (tmo_cnt_q == CW'(TMO)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
  assign tmo_hit   = (tmo_cnt_d == CW'(TMO));

  assign O_GRANT = grant_q;
  assign O_BUSY  = lock;
  assign O_TMO   = tmo_q;

  always_ff @(posedge I_AXIS_TCLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NCH - 1);
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q   <= pick_idx;
            tmo_cnt_q <= '0;
            state_q   <= LOCK;
          end
        end
        LOCK: begin
          // Only a silent source ages the watchdog; downstream backpressure keeps valid high.
          if (beat && O_AXIS_TLAST) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end else if (sel_valid) begin
            tmo_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit) begin
              last_q  <= grant_q;
              tmo_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aq_axis_arb64.sv
// Bench for aq_axis_arb64: queue-driven sources, packet-level round-robin reference.
module tb_aq_axis_arb64;
  localparam int NCH = 4;
  localparam int TMO = 8;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  typedef struct {
    int          ch;
    int          g;
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
    int          cyc;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arstn;
  logic [NCH*64-1:0] tdata;
  logic [NCH*8-1:0]  tstrb;
  logic [NCH-1:0]    tlast;
  logic [NCH-1:0]    tvalid;
  logic [NCH-1:0]    tready;
  logic [63:0]       o_data;
  logic [7:0]        o_strb;
  logic              o_last;
  logic              o_valid;
  logic              o_ready;
  logic [2:0]        o_grant;
  logic              o_busy;
  logic              o_tmo;

  aq_axis_arb64 #(.NCH(NCH), .TMO(TMO)) dut (
    .I_AXIS_TCLK   (clk),
    .ARESETN       (arstn),
    .I_AXIS_TDATA  (tdata),
    .I_AXIS_TSTRB  (tstrb),
    .I_AXIS_TLAST  (tlast),
    .I_AXIS_TVALID (tvalid),
    .I_AXIS_TREADY (tready),
    .O_AXIS_TDATA  (o_data),
    .O_AXIS_TSTRB  (o_strb),
    .O_AXIS_TLAST  (o_last),
    .O_AXIS_TVALID (o_valid),
    .O_AXIS_TREADY (o_ready),
    .O_GRANT       (o_grant),
    .O_BUSY        (o_busy),
    .O_TMO         (o_tmo)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t src_q [NCH][$];
  beat_t mdl_q [NCH][$];
  obs_t  obs_q [$];
  obs_t  exp_q [$];
  int    gap [NCH];
  bit    gaps_en = 1'b0;
  bit    rdy_rand = 1'b0;
  logic  rdy_val = 1'b1;
  int    cyc = 0;
  int    tmo_seen = 0;
  int    tmo_cyc = -1;
  int    mdl_last = NCH - 1;

  // One clock: drive sources from their queues, sample at the falling edge, log handshakes.
  task automatic cycle();
    obs_t o;
    @(posedge clk);
    #1;
    arstn = 1'b1;
    cyc++;
    for (int n = 0; n < NCH; n++) begin
      if (gap[n] > 0) begin
        gap[n]--;
        tvalid[n] = 1'b0;
      end else if (src_q[n].size() > 0) begin
        tvalid[n]         = 1'b1;
        tdata[n*64 +: 64] = src_q[n][0].d;
        tstrb[n*8 +: 8]   = src_q[n][0].s;
        tlast[n]          = src_q[n][0].l;
      end else begin
        tvalid[n] = 1'b0;
        tlast[n]  = 1'b0;
      end
    end
    o_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    @(negedge clk);
    if (o_tmo) begin
      tmo_seen++;
      tmo_cyc = cyc;
    end
    for (int n = 0; n < NCH; n++) begin
      if (tvalid[n] && tready[n]) begin
        o.ch = n; o.g = int'(o_grant); o.d = o_data; o.s = o_strb; o.l = o_last; o.cyc = cyc;
        obs_q.push_back(o);
        if (gaps_en && !src_q[n][0].l) gap[n] = $urandom_range(0, 3);
        void'(src_q[n].pop_front());
      end
    end
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int n = 0; n < NCH; n++) if (src_q[n].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int bound, output bit ok);
    int k = 0;
    while (k < bound && src_pending()) begin
      cycle();
      k++;
    end
    ok = !src_pending();
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    for (int n = 0; n < NCH; n++) begin
      src_q[n].delete();
      mdl_q[n].delete();
      gap[n] = 0;
    end
    obs_q.delete();
    exp_q.delete();
    tmo_seen = 0;
    tmo_cyc  = -1;
    mdl_last = NCH - 1;
    arstn    = 1'b0;
    cycle();
  endtask

  task automatic add_packet(input int ch, input int len, input bit fixed, input logic [63:0] fd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = fixed ? fd : {$urandom(), $urandom()};
      b.s = fixed ? 8'hFF : 8'($urandom());
      b.l = (i == len - 1);
      src_q[ch].push_back(b);
      mdl_q[ch].push_back(b);
    end
  endtask

  // Reference: whole packets served in round-robin order starting after the last served channel.
  function automatic void model_run();
    obs_t  e;
    beat_t b;
    int    c;
    bit    found;
    for (int guard = 0; guard < 1000; guard++) begin
      found = 1'b0;
      c = 0;
      for (int i = 1; i <= NCH; i++) begin
        if (!found && mdl_q[(mdl_last + i) % NCH].size() > 0) begin
          found = 1'b1;
          c = (mdl_last + i) % NCH;
        end
      end
      if (!found) break;
      b.l = 1'b0;
      while (!b.l && mdl_q[c].size() > 0) begin
        b = mdl_q[c].pop_front();
        e.ch = c; e.g = c; e.d = b.d; e.s = b.s; e.l = b.l; e.cyc = 0;
        exp_q.push_back(e);
      end
      mdl_last = c;
    end
  endfunction

  task automatic test_reset();
    for (int n = 0; n < NCH; n++) add_packet(n, 1, 1'b0, 64'h0);
    arstn = 1'b0;
    cycle();
    n_cmp += 5;
    if (o_busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    if (tready !== '0)    begin n_bad++; $display("FAIL reset_ready: got %b want 0", tready); end
    if (o_tmo !== 1'b0)   begin n_bad++; $display("FAIL reset_tmo: got %b want 0", o_tmo); end
    if (o_grant !== 3'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", o_grant); end
    $display("reset: idle bubble busy=%b valid=%b", o_busy, o_valid);
    cycle();
    n_cmp += 2;
    if (o_busy !== 1'b1)  begin n_bad++; $display("FAIL reset_first_lock: got %b want 1", o_busy); end
    if (o_grant !== 3'd0) begin n_bad++; $display("FAIL reset_first_grant: got %0d want 0", o_grant); end
    $display("reset: first grant %0d", o_grant);
    do_reset();
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    add_packet(0, 1, 1'b0, 64'h0);
    add_packet(3, 1, 1'b0, 64'h0);
    model_run();
    drain(50, ok);
    n_cmp++;
    if (ok !== 1'b1 || obs_q.size() !== 2) begin
      n_bad++; $display("FAIL simul_count: got %0d beats want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (obs_q[i].g !== i * 3 || obs_q[i].d !== exp_q[i].d) begin
          n_bad++; $display("FAIL simul_beat%0d: got g%0d d=%h want g%0d d=%h", i, obs_q[i].g, obs_q[i].d, i * 3, exp_q[i].d);
        end else $display("simul beat %0d g%0d d=%h", i, obs_q[i].g, obs_q[i].d);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int want;
    do_reset();
    for (int p = 0; p < 2; p++) for (int n = 0; n < NCH; n++) add_packet(n, 3, 1'b0, 64'h0);
    model_run();
    drain(200, ok);
    n_cmp++;
    if (ok !== 1'b1 || obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL rr_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      want = (i == 0) ? obs_q[0].cyc : obs_q[i-1].cyc + (exp_q[i-1].l ? 2 : 1);
      if (obs_q[i].g !== exp_q[i].ch || obs_q[i].ch !== exp_q[i].ch || obs_q[i].d !== exp_q[i].d ||
          obs_q[i].l !== exp_q[i].l || obs_q[i].cyc !== want) begin
        n_bad++;
        $display("FAIL rr_beat%0d: got g%0d ch%0d d=%h l=%b cyc%0d want ch%0d d=%h l=%b cyc%0d", i,
                 obs_q[i].g, obs_q[i].ch, obs_q[i].d, obs_q[i].l, obs_q[i].cyc, exp_q[i].ch, exp_q[i].d, exp_q[i].l, want);
      end else $display("rr beat %0d g%0d d=%h l=%b", i, obs_q[i].g, obs_q[i].d, obs_q[i].l);
    end
  endtask

  task automatic test_single_ch2();
    bit ok;
    do_reset();
    for (int p = 0; p < 4; p++) add_packet(2, 1, 1'b1, 64'hDEADBEEF_00000002);
    drain(50, ok);
    n_cmp++;
    if (ok !== 1'b1 || obs_q.size() !== 4) begin
      n_bad++; $display("FAIL ch2_count: got %0d beats want 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].g !== 2 || obs_q[i].d !== 64'hDEADBEEF_00000002 || obs_q[i].l !== 1'b1 ||
          (i > 0 && obs_q[i].cyc !== obs_q[i-1].cyc + 2)) begin
        n_bad++; $display("FAIL ch2_pkt%0d: got g%0d d=%h cyc%0d want g2 d=deadbeef00000002 spacing 2", i, obs_q[i].g, obs_q[i].d, obs_q[i].cyc);
      end else $display("ch2 pkt %0d g%0d d=%h cyc%0d", i, obs_q[i].g, obs_q[i].d, obs_q[i].cyc);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int k = 0;
    logic [63:0] held;
    do_reset();
    add_packet(1, 4, 1'b0, 64'h0);
    while (obs_q.size() < 1 && k < 10) begin cycle(); k++; end
    rdy_val = 1'b0;
    held = src_q[1][0].d;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_cmp++;
      if (o_tmo !== 1'b0 || tready[1] !== 1'b0 || o_valid !== 1'b1 || o_data !== held || o_busy !== 1'b1) begin
        n_bad++; $display("FAIL bp_hold%0d: got tmo=%b rdy=%b valid=%b d=%h want 0 0 1 %h", i, o_tmo, tready[1], o_valid, o_data, held);
      end
    end
    $display("backpressure: held d=%h for 20 cycles", held);
    rdy_val = 1'b1;
    model_run();
    drain(50, ok);
    n_cmp++;
    if (ok !== 1'b1 || obs_q.size() !== 4 || tmo_seen !== 0) begin
      n_bad++; $display("FAIL bp_resume: got %0d beats tmo=%0d want 4 beats tmo=0", obs_q.size(), tmo_seen);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].g !== 1 || obs_q[i].d !== exp_q[i].d || obs_q[i].l !== exp_q[i].l) begin
        n_bad++; $display("FAIL bp_beat%0d: got g%0d d=%h want g1 d=%h", i, obs_q[i].g, obs_q[i].d, exp_q[i].d);
      end else $display("bp beat %0d g%0d d=%h", i, obs_q[i].g, obs_q[i].d);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int k = 0;
    beat_t b;
    do_reset();
    b.d = 64'h0000_0000_CAFE_0000; b.s = 8'hFF; b.l = 1'b0;
    src_q[0].push_back(b);
    add_packet(1, 2, 1'b0, 64'h0);
    while (obs_q.size() < 2 && k < 60) begin cycle(); k++; end
    n_cmp++;
    if (obs_q.size() < 2) begin
      n_bad++; $display("FAIL wd_progress: got %0d beats want 2", obs_q.size());
    end else begin
      n_cmp += 3;
      if (tmo_seen !== 1 || tmo_cyc !== obs_q[0].cyc + 1 + TMO) begin
        n_bad++; $display("FAIL wd_pulse: got %0d pulses at cyc%0d want 1 at cyc%0d", tmo_seen, tmo_cyc, obs_q[0].cyc + 1 + TMO);
      end
      if (obs_q[1].g !== 1 || obs_q[1].cyc !== tmo_cyc + 1) begin
        n_bad++; $display("FAIL wd_next_grant: got g%0d cyc%0d want g1 cyc%0d", obs_q[1].g, obs_q[1].cyc, tmo_cyc + 1);
      end
      if (obs_q[1].d !== mdl_q[1][0].d) begin
        n_bad++; $display("FAIL wd_next_data: got %h want %h", obs_q[1].d, mdl_q[1][0].d);
      end
      $display("watchdog: pulse cyc%0d, next g%0d cyc%0d", tmo_cyc, obs_q[1].g, obs_q[1].cyc);
    end
    drain(50, ok);
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    int k = 0;
    do_reset();
    add_packet(3, 4, 1'b0, 64'h0);
    while (obs_q.size() < 2 && k < 20) begin cycle(); k++; end
    add_packet(0, 1, 1'b0, 64'h0);
    arstn = 1'b0;
    cycle();
    n_cmp++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_idle: got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
    obs_q.delete();
    k = 0;
    while (obs_q.size() < 1 && k < 20) begin cycle(); k++; end
    n_cmp++;
    if (obs_q.size() < 1 || obs_q[0].g !== 0) begin
      n_bad++; $display("FAIL midrst_scan: got g%0d (%0d beats) want g0", (obs_q.size() > 0) ? obs_q[0].g : -1, obs_q.size());
    end else $display("midreset: first grant after reset g%0d d=%h", obs_q[0].g, obs_q[0].d);
    drain(50, ok);
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int n = 0; n < NCH; n++)
        if ($urandom_range(0, 3) != 0)
          for (int p = 0; p < $urandom_range(1, 3); p++) add_packet(n, $urandom_range(1, 5), 1'b0, 64'h0);
      model_run();
      gaps_en  = 1'b1;
      rdy_rand = 1'b1;
      drain(3000, ok);
      gaps_en  = 1'b0;
      rdy_rand = 1'b0;
      n_cmp++;
      if (ok !== 1'b1 || obs_q.size() !== exp_q.size() || tmo_seen !== 0) begin
        n_bad++; $display("FAIL rand%0d_count: got %0d beats tmo=%0d want %0d beats tmo=0", it, obs_q.size(), tmo_seen, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i].g !== exp_q[i].ch || obs_q[i].ch !== exp_q[i].ch || obs_q[i].d !== exp_q[i].d ||
            obs_q[i].s !== exp_q[i].s || obs_q[i].l !== exp_q[i].l) begin
          n_bad++;
          $display("FAIL rand%0d_beat%0d: got g%0d ch%0d d=%h s=%h l=%b want ch%0d d=%h s=%h l=%b", it, i,
                   obs_q[i].g, obs_q[i].ch, obs_q[i].d, obs_q[i].s, obs_q[i].l, exp_q[i].ch, exp_q[i].d, exp_q[i].s, exp_q[i].l);
        end else $display("rand%0d beat %0d g%0d d=%h s=%h l=%b", it, i, obs_q[i].g, obs_q[i].d, obs_q[i].s, obs_q[i].l);
      end
    end
  endtask

  initial begin
    arstn   = 1'b0;
    tdata   = '0;
    tstrb   = '0;
    tlast   = '0;
    tvalid  = '0;
    o_ready = 1'b1;
    for (int n = 0; n < NCH; n++) gap[n] = 0;
    test_reset();
    test_simultaneous();
    test_round_robin();
    test_single_ch2();
    test_backpressure();
    test_watchdog();
    test_reset_midpacket();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
